fragment_pkt: RTL and testbench

FRAGMENT_PKT -- requirements
Module: fragment_pkt

---
 rtl/router_pkg.sv | 34 +++
 rtl/fragment_pkt.sv | 116 +++++++++++
 tb/tb_fragment_pkt.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/router_pkg.sv
// Constants shared by the fragmentation and reassembly stages.
// Covers FSM states, router ids, fragment header layout and packet layout.
package router_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_SEND = 2'b01,
    ST_DONE = 2'b10
  } frag_state_t;

  typedef enum logic [1:0] {
    ROUTER_0 = 2'd0,
    ROUTER_1 = 2'd1,
    ROUTER_2 = 2'd2,
    ROUTER_3 = 2'd3
  } router_id_t;

  // Fragment header
  localparam int HDR_SRC_LSB  = 0;
  localparam int HDR_DST_LSB  = 2;
  localparam int HDR_FRAG_LSB = 4;
  localparam int HDR_FRAG_W   = 3;
  localparam int PAYLOAD_LSB  = 9;
  localparam int PAYLOAD_W    = 247;

  // Assembled packet
  localparam int PKT_SRC_LSB  = 0;
  localparam int PKT_DST_LSB  = 2;
  localparam int PKT_SN_BIT   = 4;
  localparam int PKT_RN_BIT   = 5;
  localparam int PKT_TYPE_BIT = 6;
  localparam int PKT_DATA_LSB = 7;

endpackage

// File: rtl/fragment_pkt.sv
// Packet fragmenter: latches one DFX packet and streams it out
// as NUMBER_FRAG header-tagged words into the Aurora TX FIFO.
module fragment_pkt
  import router_pkg::*;
#(
  parameter int DATA_DFX_WIDTH = 1034,
  parameter int PKT_WIDTH = 1041,
  parameter int AURORA_WIDTH = 256,
  parameter int NUMBER_FRAG = 5,
  parameter logic [1:0] LOCAL_ROUTER_ID = ROUTER_0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pkt_valid,
  output logic pkt_ready,
  input  logic type_pkt,
  input  logic [1:0] src_dfx,
  input  logic [1:0] dst_dfx,
  input  logic pkt_sn,
  input  logic pkt_rn,
  input  logic [DATA_DFX_WIDTH-1:0] data_dfx,
  input  logic [1:0] dst_router,
  input  logic full_frag_fifo,
  output logic wr_frag_fifo,
  output logic [AURORA_WIDTH-1:0] frag_send
);

  localparam int TAIL_W =
    PKT_WIDTH - (NUMBER_FRAG - 1) * PAYLOAD_W;
  localparam logic [HDR_FRAG_W-1:0] LAST_FRAG =
    HDR_FRAG_W'(NUMBER_FRAG - 1);

  frag_state_t state, state_d;
  logic [PKT_WIDTH-1:0] pkt_reg;
  logic [1:0] dst_router_q;
  logic [HDR_FRAG_W-1:0] frag_cnt, frag_cnt_d;
  logic load;
  logic in_send;

  assign in_send = (state == ST_SEND);
  // Unknown encodings behave as IDLE, so only SEND/DONE block intake.
  assign pkt_ready = !(state == ST_SEND || state == ST_DONE);
  assign wr_frag_fifo = in_send && !full_frag_fifo;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      frag_cnt <= '0;
      pkt_reg <= '0;
      dst_router_q <= '0;
    end else begin
      state <= state_d;
      frag_cnt <= frag_cnt_d;
      if (load) begin
        pkt_reg[PKT_SRC_LSB +: 2] <= src_dfx;
        pkt_reg[PKT_DST_LSB +: 2] <= dst_dfx;
        pkt_reg[PKT_SN_BIT] <= pkt_sn;
        pkt_reg[PKT_RN_BIT] <= pkt_rn;
        pkt_reg[PKT_TYPE_BIT] <= type_pkt;
        pkt_reg[PKT_DATA_LSB +: DATA_DFX_WIDTH] <= data_dfx;
        dst_router_q <= dst_router;
      end
    end
  end

  always_comb begin
    state_d = ST_IDLE;
    frag_cnt_d = frag_cnt;
    load = 1'b0;
    case (state)
      ST_SEND: begin
        state_d = ST_SEND;
        if (wr_frag_fifo) begin
          frag_cnt_d = frag_cnt + 1'b1;
          if (frag_cnt == LAST_FRAG) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        frag_cnt_d = '0;
      end
      default: begin
        if (pkt_valid) begin
          state_d = ST_SEND;
          frag_cnt_d = '0;
          load = 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    frag_send = '0;
    if (in_send) begin
      frag_send[HDR_SRC_LSB +: 2] = LOCAL_ROUTER_ID;
      frag_send[HDR_DST_LSB +: 2] = dst_router_q;
      frag_send[HDR_FRAG_LSB +: HDR_FRAG_W] = frag_cnt;
      case (frag_cnt)
        3'd0: frag_send[PAYLOAD_LSB +: PAYLOAD_W] =
          pkt_reg[0 * PAYLOAD_W +: PAYLOAD_W];
        3'd1: frag_send[PAYLOAD_LSB +: PAYLOAD_W] =
          pkt_reg[1 * PAYLOAD_W +: PAYLOAD_W];
        3'd2: frag_send[PAYLOAD_LSB +: PAYLOAD_W] =
          pkt_reg[2 * PAYLOAD_W +: PAYLOAD_W];
        3'd3: frag_send[PAYLOAD_LSB +: PAYLOAD_W] =
          pkt_reg[3 * PAYLOAD_W +: PAYLOAD_W];
        // Last fragment carries only the short tail, rest stays zero.
        default: frag_send[PAYLOAD_LSB +: TAIL_W] =
          pkt_reg[PKT_WIDTH-1 -: TAIL_W];
      endcase
    end
  end

endmodule

// File: tb/tb_fragment_pkt.sv
// Directed bench for fragment_pkt: latency, backpressure,
// back-to-back, ack, mid-packet reset and reassembly loopback.
module tb_fragment_pkt;

  typedef logic [1040:0] cv_t;

  logic clk;
  logic rst_n;
  logic pkt_valid;
  logic pkt_ready;
  logic type_pkt;
  logic [1:0] src_dfx;
  logic [1:0] dst_dfx;
  logic pkt_sn;
  logic pkt_rn;
  logic [1033:0] data_dfx;
  logic [1:0] dst_router;
  logic full_frag_fifo;
  logic wr_frag_fifo;
  logic [255:0] frag_send;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  logic [255:0] fq[$];
  int fc[$];
  int acc[$];

  fragment_pkt dut (
    .clk(clk),
    .rst_n(rst_n),
    .pkt_valid(pkt_valid),
    .pkt_ready(pkt_ready),
    .type_pkt(type_pkt),
    .src_dfx(src_dfx),
    .dst_dfx(dst_dfx),
    .pkt_sn(pkt_sn),
    .pkt_rn(pkt_rn),
    .data_dfx(data_dfx),
    .dst_router(dst_router),
    .full_frag_fifo(full_frag_fifo),
    .wr_frag_fifo(wr_frag_fifo),
    .frag_send(frag_send)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (wr_frag_fifo) begin
      fq.push_back(frag_send);
      fc.push_back(cyc);
    end
    if (rst_n && pkt_valid && pkt_ready) acc.push_back(cyc);
  end

  task automatic chk(input string tag, input cv_t got,
                     input cv_t exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_frags(input string tag, input int n);
    for (int i = 0; i < 40 && fq.size() < n; i++) step();
    chk(tag, cv_t'(fq.size()), cv_t'(n));
  endtask

  task automatic settle();
    for (int i = 0; i < 20 && !pkt_ready; i++) step();
    step();
    fq.delete();
    fc.delete();
    acc.delete();
  endtask

  task automatic set_pkt(input logic t, input logic [1:0] s,
                         input logic [1:0] d, input logic sn,
                         input logic rn, input logic [1033:0] dat,
                         input logic [1:0] rt);
    type_pkt = t;
    src_dfx = s;
    dst_dfx = d;
    pkt_sn = sn;
    pkt_rn = rn;
    data_dfx = dat;
    dst_router = rt;
  endtask

  function automatic cv_t mk_pkt(input logic t, input logic [1:0] s,
                                 input logic [1:0] d, input logic sn,
                                 input logic rn,
                                 input logic [1033:0] dat);
    return {dat, t, rn, sn, d, s};
  endfunction

  function automatic logic [1033:0] gen_data(input int k);
    logic [1055:0] t;
    for (int i = 0; i < 33; i++)
      t[i*32 +: 32] = 32'(32'h1000_0001 * (k + 1) + i * 32'h0101_0101);
    return t[1033:0];
  endfunction

  function automatic cv_t reasm(input int b);
    cv_t r;
    r = '0;
    for (int i = 0; i < 4; i++) r[i*247 +: 247] = fq[b+i][255:9];
    r[1040:988] = fq[b+4][61:9];
    return r;
  endfunction

  function automatic logic [255:0] exp_frag(input cv_t p,
                                            input logic [1:0] rt,
                                            input int k);
    logic [255:0] f;
    f = '0;
    f[3:2] = rt;
    f[6:4] = 3'(k);
    if (k < 4) f[255:9] = p[k*247 +: 247];
    else f[61:9] = p[1040:988];
    return f;
  endfunction

  initial begin
    logic [1033:0] dat, dat_b;
    logic [8:0] hdr[5];
    cv_t pa, pb, r;
    int p, q;

    rst_n = 1'b0;
    pkt_valid = 1'b0;
    full_frag_fifo = 1'b0;
    set_pkt(1'b0, 2'd0, 2'd0, 1'b0, 1'b0, '0, 2'd0);
    #1;
    chk("rst_ready", cv_t'(pkt_ready), cv_t'(1));
    chk("rst_wr", cv_t'(wr_frag_fifo), cv_t'(0));
    chk("rst_frag", cv_t'(frag_send), cv_t'(0));
    step();
    step();
    rst_n = 1'b1;
    step();

    // Single data packet with incrementing bytes
    for (int i = 0; i < 1034; i++) begin
      logic [7:0] bt;
      bt = 8'(i / 8);
      dat[i] = bt[i % 8];
    end
    hdr = '{9'h004, 9'h014, 9'h024, 9'h034, 9'h044};
    set_pkt(1'b0, 2'd1, 2'd2, 1'b1, 1'b0, dat, 2'd1);
    pkt_valid = 1'b1;
    p = cyc;
    step();
    pkt_valid = 1'b0;
    repeat (5) step();
    chk("t1_done_ready", cv_t'(pkt_ready), cv_t'(0));
    step();
    chk("t1_idle_ready", cv_t'(pkt_ready), cv_t'(1));
    wait_frags("t1_count", 5);
    chk("t1_acc", cv_t'(acc[0]), cv_t'(p));
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("t1_hdr%0d", k), cv_t'(fq[k][8:0]), cv_t'(hdr[k]));
      chk($sformatf("t1_cyc%0d", k), cv_t'(fc[k]), cv_t'(p + 1 + k));
    end
    chk("t1_fields", cv_t'(fq[0][15:9]), cv_t'(7'h19));
    chk("t1_byte1", cv_t'(fq[0][31:24]), cv_t'(8'h01));
    chk("t1_tailzero", cv_t'(fq[4][255:62]), cv_t'(0));
    chk("t1_payload", reasm(0), mk_pkt(1'b0, 2'd1, 2'd2, 1'b1, 1'b0, dat));
    settle();

    // Backpressure for 3 cycles after fragment 1
    dat = gen_data(1);
    pa = mk_pkt(1'b0, 2'd3, 2'd1, 1'b0, 1'b1, dat);
    set_pkt(1'b0, 2'd3, 2'd1, 1'b0, 1'b1, dat, 2'd3);
    pkt_valid = 1'b1;
    p = cyc;
    step();
    pkt_valid = 1'b0;
    step();
    step();
    full_frag_fifo = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("t2_nowr%0d", i), cv_t'(wr_frag_fifo), cv_t'(0));
      chk($sformatf("t2_hold%0d", i), cv_t'(frag_send),
          cv_t'(exp_frag(pa, 2'd3, 2)));
      step();
    end
    full_frag_fifo = 1'b0;
    wait_frags("t2_count", 5);
    chk("t2_cyc2", cv_t'(fc[2]), cv_t'(p + 6));
    chk("t2_cyc4", cv_t'(fc[4]), cv_t'(p + 8));
    chk("t2_fno2", cv_t'(fq[2][6:4]), cv_t'(2));
    chk("t2_payload", reasm(0), pa);
    repeat (3) step();
    chk("t2_total", cv_t'(fq.size()), cv_t'(5));
    settle();

    // Back-to-back with pkt_valid held high
    dat = gen_data(2);
    dat_b = gen_data(3);
    pa = mk_pkt(1'b0, 2'd0, 2'd3, 1'b1, 1'b1, dat);
    pb = mk_pkt(1'b0, 2'd2, 2'd0, 1'b0, 1'b0, dat_b);
    set_pkt(1'b0, 2'd0, 2'd3, 1'b1, 1'b1, dat, 2'd2);
    pkt_valid = 1'b1;
    step();
    set_pkt(1'b0, 2'd2, 2'd0, 1'b0, 1'b0, dat_b, 2'd1);
    for (int i = 0; i < 20 && acc.size() < 2; i++) step();
    pkt_valid = 1'b0;
    chk("t3_nacc", cv_t'(acc.size()), cv_t'(2));
    chk("t3_gap", cv_t'(acc[1] - acc[0]), cv_t'(7));
    wait_frags("t3_count", 10);
    for (int k = 0; k < 10; k++)
      chk($sformatf("t3_fno%0d", k), cv_t'(fq[k][6:4]),
          cv_t'(k % 5));
    chk("t3_cyc9", cv_t'(fc[9]), cv_t'(acc[0] + 12));
    chk("t3_pkt_a", reasm(0), pa);
    chk("t3_pkt_b", reasm(5), pb);
    chk("t3_rt_b", cv_t'(fq[5][3:2]), cv_t'(1));
    settle();

    // Ack packet
    set_pkt(1'b1, 2'd3, 2'd0, 1'b0, 1'b1, gen_data(4), 2'd2);
    pkt_valid = 1'b1;
    step();
    pkt_valid = 1'b0;
    wait_frags("t4_count", 5);
    chk("t4_ackbit", cv_t'(fq[0][15]), cv_t'(1));
    chk("t4_hdr0", cv_t'(fq[0][8:0]), cv_t'(9'h008));
    settle();

    // Reset after fragment 2 write
    set_pkt(1'b0, 2'd1, 2'd1, 1'b1, 1'b0, gen_data(5), 2'd3);
    pkt_valid = 1'b1;
    step();
    pkt_valid = 1'b0;
    step();
    step();
    step();
    chk("t5_pre", cv_t'(fq.size()), cv_t'(3));
    rst_n = 1'b0;
    #1;
    chk("t5_wr", cv_t'(wr_frag_fifo), cv_t'(0));
    chk("t5_ready", cv_t'(pkt_ready), cv_t'(1));
    chk("t5_frag", cv_t'(frag_send), cv_t'(0));
    step();
    step();
    chk("t5_held", cv_t'(fq.size()), cv_t'(3));
    dat = gen_data(6);
    pa = mk_pkt(1'b0, 2'd2, 2'd3, 1'b0, 1'b1, dat);
    set_pkt(1'b0, 2'd2, 2'd3, 1'b0, 1'b1, dat, 2'd0);
    pkt_valid = 1'b1;
    rst_n = 1'b1;
    q = cyc;
    step();
    pkt_valid = 1'b0;
    wait_frags("t5_count", 8);
    chk("t5_acc", cv_t'(acc[acc.size()-1]), cv_t'(q));
    chk("t5_fno", cv_t'(fq[3][6:4]), cv_t'(0));
    chk("t5_cyc", cv_t'(fc[3]), cv_t'(q + 1));
    chk("t5_payload", reasm(3), pa);
    settle();

    // Loopback through a reassembly model
    for (int j = 0; j < 4; j++) begin
      logic [1:0] s, d;
      s = 2'(3 - j);
      d = 2'(j);
      dat = gen_data(10 + j);
      set_pkt(1'b0, s, d, 1'(j), 1'(j >> 1), dat, 2'(j));
      pkt_valid = 1'b1;
      step();
      pkt_valid = 1'b0;
      wait_frags($sformatf("t6_count%0d", j), 5);
      r = reasm(0);
      chk($sformatf("t6_data%0d", j), cv_t'(r[1040:7]), cv_t'(dat));
      chk($sformatf("t6_src%0d", j), cv_t'(r[1:0]), cv_t'(s));
      chk($sformatf("t6_dst%0d", j), cv_t'(r[3:2]), cv_t'(d));
      chk($sformatf("t6_sn%0d", j), cv_t'(r[4]), cv_t'(j & 1));
      chk($sformatf("t6_rn%0d", j), cv_t'(r[5]), cv_t'((j >> 1) & 1));
      settle();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
